// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults and address-width helper for the register bank
package reg_bank_pkg;
  localparam int REG_BANK_NUM_REGS = 16;
  localparam int REG_BANK_WIDTH = 32;
  localparam int REG_ZERO_ADDR = 0;
  function automatic int calc_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: one registered read port with range check, write bypass and valid pulse (honours REG_ZERO_HARDWIRED_EN)
module reg_read_port import reg_bank_pkg::*; #(
  parameter int NUM_REGS = REG_BANK_NUM_REGS,
  parameter int WIDTH = REG_BANK_WIDTH,
  localparam int AW = calc_aw(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REGS*WIDTH-1:0] mem,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid
);
  logic in_range;
  logic is_zero;
  logic bypass;
  logic [WIDTH-1:0] sel;
  // pick out-of-range/zero, then same-cycle write data, then stored word
  always_comb begin
    in_range = int'({1'b0, rd_addr}) < NUM_REGS;
`ifdef REG_ZERO_HARDWIRED_EN
    is_zero = rd_addr == AW'(REG_ZERO_ADDR);
`else
    is_zero = 1'b0;
`endif
    bypass = wr_en && wr_addr == rd_addr;
    sel = (!in_range || is_zero) ? '0 : bypass ? wr_data : mem[int'({1'b0, rd_addr})*WIDTH +: WIDTH];
  end
  // output register: data loads on request and holds otherwise, valid pulses per request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= sel;
    end
  end
endmodule

// File: rtl/reg_bank_rd2w1.sv
// reg_bank_rd2w1: NUM_REGS x WIDTH register bank, one write port, two registered read ports (REG_ZERO_HARDWIRED_EN makes address 0 read-only zero)
module reg_bank_rd2w1 import reg_bank_pkg::*; #(
  parameter int NUM_REGS = REG_BANK_NUM_REGS,
  parameter int WIDTH = REG_BANK_WIDTH,
  localparam int AW = calc_aw(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b
);
  logic [NUM_REGS*WIDTH-1:0] mem;
  logic wr_ok;
  // a write lands only for in-range addresses that are not the hardwired zero register
  always_comb begin
`ifdef REG_ZERO_HARDWIRED_EN
    wr_ok = wr_en && int'({1'b0, wr_addr}) < NUM_REGS && wr_addr != AW'(REG_ZERO_ADDR);
`else
    wr_ok = wr_en && int'({1'b0, wr_addr}) < NUM_REGS;
`endif
  end
  // storage update
  always_ff @(posedge clk) begin
    if (!rst_n) mem <= '0;
    else if (wr_ok) mem[int'({1'b0, wr_addr})*WIDTH +: WIDTH] <= wr_data;
  end
  reg_read_port #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_port_a (
    .clk(clk), .rst_n(rst_n), .mem(mem),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );
  reg_read_port #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_port_b (
    .clk(clk), .rst_n(rst_n), .mem(mem),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );
endmodule

// File: tb/tb_reg_bank_rd2w1.sv
// tb_reg_bank_rd2w1: directed bench for reg_bank_rd2w1 (16-word and 12-word instances share stimulus)
module tb_reg_bank_rd2w1;
  logic clk = 1'b0;
  logic rst_n;
  logic wr_en;
  logic [3:0] wr_addr;
  logic [31:0] wr_data;
  logic rd_en_a, rd_en_b;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [31:0] da16, db16, da12, db12;
  logic va16, vb16, va12, vb12;
  int checks = 0;
  int errors = 0;
  logic [31:0] m16 [16];
  logic [31:0] m12 [12];
  logic [31:0] xa16 = '0, xb16 = '0, xa12 = '0, xb12 = '0;
  logic xva = 1'b0, xvb = 1'b0;
  logic [31:0] zexp;

  always #5 clk = ~clk;

  reg_bank_rd2w1 u16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da16), .rd_valid_a(va16),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db16), .rd_valid_b(vb16)
  );
  reg_bank_rd2w1 #(.NUM_REGS(12)) u12 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da12), .rd_valid_a(va12),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db12), .rd_valid_b(vb12)
  );

  function automatic logic [31:0] pick(input int n, input int addr, input logic [31:0] stored);
    if (addr >= n) return 32'h0;
`ifdef REG_ZERO_HARDWIRED_EN
    if (addr == 0) return 32'h0;
`endif
    if (wr_en && int'(wr_addr) == addr) return wr_data;
    return stored;
  endfunction

  function automatic logic wr_allowed(input int n);
`ifdef REG_ZERO_HARDWIRED_EN
    if (wr_addr == 4'd0) return 1'b0;
`endif
    return wr_en && int'(wr_addr) < n;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: reads see pre-write contents, then the write is applied
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m16[i] = '0;
      for (int i = 0; i < 12; i++) m12[i] = '0;
      xa16 = '0; xb16 = '0; xa12 = '0; xb12 = '0; xva = 1'b0; xvb = 1'b0;
    end else begin
      xva = rd_en_a;
      xvb = rd_en_b;
      if (rd_en_a) begin
        xa16 = pick(16, int'(rd_addr_a), m16[rd_addr_a]);
        xa12 = pick(12, int'(rd_addr_a), int'(rd_addr_a) < 12 ? m12[rd_addr_a] : 32'h0);
      end
      if (rd_en_b) begin
        xb16 = pick(16, int'(rd_addr_b), m16[rd_addr_b]);
        xb12 = pick(12, int'(rd_addr_b), int'(rd_addr_b) < 12 ? m12[rd_addr_b] : 32'h0);
      end
      if (wr_allowed(16)) m16[wr_addr] = wr_data;
      if (wr_allowed(12)) m12[wr_addr] = wr_data;
    end
  end

  // compare every cycle, away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp("u16.data_a", da16, xa16);
      cmp("u16.data_b", db16, xb16);
      cmp("u16.valid_a", {31'b0, va16}, {31'b0, xva});
      cmp("u16.valid_b", {31'b0, vb16}, {31'b0, xvb});
      cmp("u12.data_a", da12, xa12);
      cmp("u12.data_b", db12, xb12);
      cmp("u12.valid_a", {31'b0, va12}, {31'b0, xva});
      cmp("u12.valid_b", {31'b0, vb12}, {31'b0, xvb});
    end
  end

  initial begin
`ifdef REG_ZERO_HARDWIRED_EN
    zexp = 32'h0;
`else
    zexp = 32'hFFFFFFFF;
`endif
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b1; rd_addr_a = 4'd5; rd_en_b = 1'b0; rd_addr_b = '0;
    repeat (2) step();
    cmp("reset.valid_a", {31'b0, va16}, 32'd0);
    cmp("reset.data_a", da16, 32'd0);
    rst_n = 1'b1;
    step();
    cmp("post_reset.valid_a", {31'b0, va16}, 32'd1);
    cmp("post_reset.data_a", da16, 32'd0);
    rd_en_a = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd3;
    step();
    cmp("basic.data_a", da16, 32'hDEADBEEF);
    cmp("basic.valid_a", {31'b0, va16}, 32'd1);
    cmp("basic.valid_b", {31'b0, vb16}, 32'd0);
    rd_en_a = 1'b0; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h11111111;
    step();
    wr_data = 32'h22222222; rd_en_a = 1'b1; rd_addr_a = 4'd7; rd_en_b = 1'b1; rd_addr_b = 4'd7;
    step();
    cmp("bypass.data_a", da16, 32'h22222222);
    cmp("bypass.data_b", db16, 32'h22222222);
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i); wr_data = 32'h100 + 32'(i);
      step();
    end
    wr_en = 1'b0; rd_en_a = 1'b1; rd_en_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      step();
      if (i == 5) begin
        cmp("stream.data_a5", da16, 32'h105);
        cmp("stream.data_b10", db16, 32'h10A);
      end
    end
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    step();
    cmp("drop.valid_a", {31'b0, va16}, 32'd0);
    cmp("drop.hold_a", da16, 32'h10F);
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hABCD;
    step();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd13; rd_en_b = 1'b1; rd_addr_b = 4'd11;
    step();
    cmp("oor12.data_a", da12, 32'h0);
    cmp("oor12.data_b", db12, 32'h10B);
    cmp("in16.data_a", da16, 32'hABCD);
    rd_en_b = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 4'd0;
    step();
    cmp("zero.bypass", da16, zexp);
    wr_en = 1'b0;
    step();
    cmp("zero.reread", da16, zexp);
    rst_n = 1'b0; rd_en_a = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h5555AAAA;
    step();
    rst_n = 1'b1; wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd4;
    step();
    cmp("reset_discard.data_a", da16, 32'h0);
    rd_en_a = 1'b0;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
